// File: rtl/alu_op_sequencer.sv
// Register-register instruction sequencer wrapped around an external 4-bit ALU: OPER/EXEC/WB.
// Latency: accept at T, write-back and done at T+3, result readable on dbg_data at T+4.
// Backpressure: instr_ready only in IDLE with no direct load pending; 1 instruction per 4 cycles.
module alu_op_sequencer #(
    parameter int N    = 4,
    parameter int NREG = 4,
    localparam int AW  = $clog2(NREG),
    localparam int IW  = 1 + 4 + 3 * AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [N-1:0]  load_data,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_control,
    input  logic [N-1:0]  alu_result,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags_q,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    typedef struct packed {
        logic          wen;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
    } instr_t;

    typedef enum logic [1:0] {IDLE, OPER, EXEC, WB} state_t;

    state_t         state;
    state_t         state_nxt;
    instr_t         ir;
    logic [N-1:0]   rf [NREG];
    logic [N-1:0]   res_q;
    logic [3:0]     flg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = ~load_en;
                if (instr_valid && !load_en) begin
                    state_nxt = OPER;
                end
            end
            OPER:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are sampled in OPER, so a write-back to rd==ra cannot disturb the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            ir          <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            res_q       <= '0;
            flg_q       <= '0;
            flags_q     <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state == EXEC);
            case (state)
                IDLE: begin
                    if (load_en) begin
                        rf[load_addr] <= load_data;
                    end else if (instr_valid) begin
                        ir <= instr_t'(instr);
                    end
                end
                OPER: begin
                    alu_a       <= rf[ir.ra];
                    alu_b       <= rf[ir.rb];
                    alu_control <= ir.op;
                end
                EXEC: begin
                    res_q <= alu_result;
                    flg_q <= alu_flags;
                end
                WB: begin
                    if (ir.wen) begin
                        rf[ir.rd] <= res_q;
                    end
                    // Flags commit even with wen=0 so the instruction can serve as a compare.
                    flags_q <= flg_q;
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 4-bit ALU and an instruction-level reference model.
module tb_alu_op_sequencer;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0101;
    localparam logic [3:0] AND = 4'b1000;
    localparam logic [3:0] OR  = 4'b1001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [10:0] instr = '0;
    logic        load_en = 1'b0;
    logic [1:0]  load_addr = '0;
    logic [3:0]  load_data = '0;
    logic [3:0]  alu_a, alu_b, alu_control;
    logic [3:0]  alu_result, alu_flags;
    logic [3:0]  flags_q;
    logic        done;
    logic [1:0]  dbg_addr = '0;
    logic [3:0]  dbg_data;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU: result plus flags {over,neg,zero,carr}; flags come from the adder (add for ADD, subtract otherwise).
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [4:0] s;
        logic [3:0] bb, r;
        logic       sub, ov;
        sub = (op != ADD);
        bb  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + {4'b0, sub};
        ov  = (a[3] == bb[3]) && (s[3] != a[3]);
        case (op)
            AND:     r = a & b;
            OR:      r = a | b;
            default: r = s[3:0];
        endcase
        return {r, ov, s[3] ^ ov, (r == 4'd0), s[4]};
    endfunction

    logic [7:0] alu_out;
    assign alu_out    = alu_fn(alu_a, alu_b, alu_control);
    assign alu_result = alu_out[7:4];
    assign alu_flags  = alu_out[3:0];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted instruction computes its effect immediately and
    // commits it three cycles later; phase is cycles since acceptance (0 = idle).
    logic [3:0] rf_m [4];
    logic [3:0] flags_m, res_m, flg_m, ea, eb, eop;
    logic [1:0] rd_m;
    logic       wen_m;
    int         phase;
    logic [7:0] tmp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
            flags_m = 4'd0; ea = 4'd0; eb = 4'd0; eop = 4'd0;
            phase = 0;
        end else if (phase == 0) begin
            if (load_en) begin
                rf_m[load_addr] = load_data;
            end else if (instr_valid) begin
                wen_m = instr[10];
                eop   = instr[9:6];
                rd_m  = instr[5:4];
                ea    = rf_m[instr[3:2]];
                eb    = rf_m[instr[1:0]];
                tmp   = alu_fn(ea, eb, eop);
                res_m = tmp[7:4];
                flg_m = tmp[3:0];
                phase = 1;
            end
        end else if (phase == 3) begin
            if (wen_m) rf_m[rd_m] = res_m;
            flags_m = flg_m;
            phase = 0;
        end else begin
            phase = phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("done", done, (phase == 3));
            chk("instr_ready", instr_ready, (phase == 0 && !load_en));
            chk("dbg_data", dbg_data, rf_m[dbg_addr]);
            chk("flags_q", flags_q, flags_m);
            if (phase != 1) begin
                chk("alu_a", alu_a, ea);
                chk("alu_b", alu_b, eb);
                chk("alu_control", alu_control, eop);
            end
        end
    end

    task automatic rd_reg(input logic [1:0] a, output int v);
        dbg_addr = a;
        #1 v = dbg_data;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [3:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1 load_en = 1'b0;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (instr_ready) acc = 1'b1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk); #1 instr_valid = 1'b0;
    endtask

    // Issues one instruction; reports the negedge index of done after acceptance and how many cycles done was high.
    task automatic issue(input logic wen, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, output int lat, output int ndone);
        instr = {wen, op, rd, ra, rb};
        instr_valid = 1'b1;
        lat = -1; ndone = 0;
        wait_accept();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
        end
        @(posedge clk); #1;
    endtask

    int lat, nd, v;

    initial begin
        tmp = alu_fn(4'd3, 4'd5, ADD); chk("pin_add", tmp, {4'd8, 4'b1000});
        tmp = alu_fn(4'd3, 4'd3, SUB); chk("pin_sub", tmp, {4'd0, 4'b0011});
        tmp = alu_fn(4'd3, 4'd5, AND); chk("pin_and", tmp, {4'd1, 4'b0100});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_ready", instr_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_flags", flags_q, 0);

        do_load(2'd1, 4'd3);
        do_load(2'd2, 4'd5);
        issue(1'b1, ADD, 2'd3, 2'd1, 2'd2, lat, nd);
        chk("t1_latency", lat, 3);
        rd_reg(2'd3, v); chk("t1_r3", v, 8);
        chk("t1_flags", flags_q, 4'b1000);

        issue(1'b1, SUB, 2'd0, 2'd1, 2'd1, lat, nd);
        rd_reg(2'd0, v); chk("t2_r0", v, 0);
        chk("t2_flags", flags_q, 4'b0011);

        issue(1'b1, AND, 2'd1, 2'd1, 2'd2, lat, nd);
        rd_reg(2'd1, v); chk("t3_r1", v, 1);
        chk("t3_flags", flags_q, 4'b0100);

        issue(1'b0, SUB, 2'd0, 2'd2, 2'd1, lat, nd);
        chk("t4_flags", flags_q, 4'b0001);
        chk("t4_done_once", nd, 1);
        rd_reg(2'd0, v); chk("t4_r0", v, 0);
        rd_reg(2'd1, v); chk("t4_r1", v, 1);
        rd_reg(2'd2, v); chk("t4_r2", v, 5);
        rd_reg(2'd3, v); chk("t4_r3", v, 8);

        // Load and instruction offered together: load wins, instruction waits one cycle.
        instr = {1'b1, ADD, 2'd2, 2'd0, 2'd1};
        instr_valid = 1'b1;
        load_en = 1'b1; load_addr = 2'd0; load_data = 4'd7;
        @(negedge clk); chk("t5_ready_load", instr_ready, 0);
        @(posedge clk); #1 load_en = 1'b0;
        @(negedge clk); chk("t5_ready_next", instr_ready, 1);
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1 load_en = 1'b1; load_addr = 2'd3; load_data = 4'd15;
        @(posedge clk); #1 load_en = 1'b0;
        @(negedge clk); chk("t5_done", done, 1);
        @(posedge clk); #1;
        rd_reg(2'd2, v); chk("t5_r2", v, 8);
        rd_reg(2'd3, v); chk("t5_r3_ignored", v, 8);
        rd_reg(2'd0, v); chk("t5_r0", v, 7);
        chk("t5_flags", flags_q, 4'b1000);

        // Reset in EXEC drops the instruction.
        instr = {1'b1, ADD, 2'd3, 2'd1, 2'd2};
        instr_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("t6_ready", instr_ready, 1);
        chk("t6_done", done, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_alu_control", alu_control, 0);
        chk("t6_flags", flags_q, 0);
        for (int i = 0; i < 4; i++) begin
            rd_reg(i[1:0], v); chk("t6_rf", v, 0);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t6_no_done", done, 0);
        rd_reg(2'd3, v); chk("t6_r3", v, 0);

        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            load_en     = ($urandom_range(0, 3) == 0);
            load_addr   = 2'($urandom_range(0, 3));
            load_data   = 4'($urandom_range(0, 15));
            instr_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: instr[9:6] = ADD;
                1: instr[9:6] = SUB;
                2: instr[9:6] = AND;
                default: instr[9:6] = OR;
            endcase
            instr[10]  = ($urandom_range(0, 3) != 0);
            instr[5:0] = 6'($urandom_range(0, 63));
            dbg_addr   = 2'($urandom_range(0, 3));
        end
        instr_valid = 1'b0;
        load_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
